mem_refill_arbiter: RTL and testbench

Refill/write-back sequencer sharing one single-port main memory between the instruction-side and data-side L1 caches (direct-mapped, write-back, 8-word/32-byte blocks). On a miss it grants one side, writes back the dirty victim block if present, then streams the new block from memory into the requesting cache one word per accepted beat. It sits between both caches and main memory and is the only master of the memory port.

---
 rtl/mem_refill_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_refill_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: sequencer that shares one single-port main memory
// between the I-side and D-side L1 caches. It grants one side on a miss,
// writes back a dirty D-side victim block if one is present, then streams
// the refill block into the granted cache one word per accepted beat.
module mem_refill_arbiter #(
  parameter  int unsigned WORDS  = 8,
  localparam int unsigned BEAT_W = $clog2(WORDS)
) (
  input  logic              clock,
  input  logic              resetn,
  // I-cache side
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  // D-cache side
  input  logic              d_req,
  input  logic              d_wb,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wb_addr,
  input  logic [31:0]       d_wb_data,
  // grants and fill path back to the caches
  output logic              gnt_i,
  output logic              gnt_d,
  output logic [BEAT_W-1:0] beat,
  output logic [31:0]       fill_data,
  output logic              fill_we_i,
  output logic              fill_we_d,
  output logic              i_done,
  output logic              d_done,
  // main memory port
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  // Byte offset inside a block: word index plus the 2-bit byte-in-word.
  localparam int unsigned OFF_W = BEAT_W + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_RD,
    S_DONE
  } state_e;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_e;

  state_e              state_q, state_d;
  side_e               side_q, side_d;   // side owning the current transfer
  side_e               last_q, last_d;   // side granted by the last completed transfer
  side_e               pick;             // arbitration winner in IDLE
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [31:OFF_W]     rd_base_q, rd_base_d;
  logic [31:OFF_W]     wb_base_q, wb_base_d;
  logic                last_beat;

  // Block-offset address bits are not part of any block base.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0],
                                d_wb_addr[OFF_W-1:0]};

  assign last_beat = (beat_q == BEAT_W'(WORDS - 1));

  // State register: sequencer state, grant bookkeeping, beat and latched bases.
  // NOTE: every flop (addresses included) is reset, so an abandoned transfer
  // leaves no stale base or beat behind that could leak onto the memory port.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      side_q    <= SIDE_I;
      last_q    <= SIDE_I;
      beat_q    <= '0;
      rd_base_q <= '0;
      wb_base_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from the
      // same pre-edge values regardless of statement order.
      state_q   <= state_d;
      side_q    <= side_d;
      last_q    <= last_d;
      beat_q    <= beat_d;
      rd_base_q <= rd_base_d;
      wb_base_q <= wb_base_d;
    end
  end

  // Next-state logic: round-robin arbitration, write-back, refill, completion.
  always_comb begin
    // NOTE: hold-value defaults first so no path through the case infers a latch.
    state_d   = state_q;
    side_d    = side_q;
    last_d    = last_q;
    beat_d    = beat_q;
    rd_base_d = rd_base_q;
    wb_base_d = wb_base_q;
    pick      = SIDE_I;

    case (state_q)
      S_IDLE: begin
        if (i_req && d_req) begin
          pick = (last_q == SIDE_I) ? SIDE_D : SIDE_I;
        end else if (d_req) begin
          pick = SIDE_D;
        end
        if (i_req || d_req) begin
          side_d    = pick;
          beat_d    = '0;
          rd_base_d = (pick == SIDE_D) ? d_addr[31:OFF_W] : i_addr[31:OFF_W];
          wb_base_d = d_wb_addr[31:OFF_W];
          state_d   = (pick == SIDE_D && d_wb) ? S_WB : S_RD;
        end
      end

      S_WB: begin
        if (mem_ready) begin
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_RD;
          end
        end
      end

      S_RD: begin
        if (mem_ready) begin
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        last_d  = side_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: memory port, fill strobes, grants and done pulses.
  always_comb begin
    gnt_i     = (state_q != S_IDLE) && (side_q == SIDE_I);
    gnt_d     = (state_q != S_IDLE) && (side_q == SIDE_D);
    mem_wr    = (state_q == S_WB);
    mem_rd    = (state_q == S_RD);
    fill_we_i = (state_q == S_RD) && mem_ready && (side_q == SIDE_I);
    fill_we_d = (state_q == S_RD) && mem_ready && (side_q == SIDE_D);
    i_done    = (state_q == S_DONE) && (side_q == SIDE_I);
    d_done    = (state_q == S_DONE) && (side_q == SIDE_D);
    beat      = beat_q;
    fill_data = mem_rdata;
    mem_wdata = d_wb_data;
    mem_addr  = '0;
    if (state_q == S_WB) begin
      mem_addr = {wb_base_q, beat_q, 2'b00};
    end else if (state_q == S_RD) begin
      mem_addr = {rd_base_q, beat_q, 2'b00};
    end
  end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// tb_mem_refill_arbiter: scoreboard bench. Each issued miss pushes its
// expected memory beats and completion into a queue; an independent monitor
// pops and compares whenever the DUT shows a write-back beat, a fill beat or
// a done pulse.
module tb_mem_refill_arbiter;

  localparam int WORDS  = 8;
  localparam int BEAT_W = 3;
  localparam int K_WR   = 0;
  localparam int K_RD   = 1;
  localparam int K_DONE = 2;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              i_req = 1'b0, d_req = 1'b0, d_wb = 1'b0;
  logic [31:0]       i_addr = '0, d_addr = '0, d_wb_addr = '0;
  logic [31:0]       d_wb_data, mem_rdata;
  logic              mem_ready = 1'b1;
  logic              gnt_i, gnt_d, fill_we_i, fill_we_d, i_done, d_done;
  logic              mem_rd, mem_wr;
  logic [BEAT_W-1:0] beat;
  logic [31:0]       fill_data, mem_addr, mem_wdata;

  typedef struct {
    int          kind;
    bit          side;   // 0 = I, 1 = D
    logic [31:0] addr;
    logic [31:0] data;
    int          beat;
  } exp_t;

  exp_t sb[$];
  bit   model_last = 1'b0;   // side of the last completed grant
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cycle_cnt = 0;
  int   ready_mode = 0;      // 0 always ready, 1 random, 2 scripted stall
  int   stall_cnt = 0;

  mem_refill_arbiter #(.WORDS(WORDS)) dut (
    .clock(clock), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wb(d_wb), .d_addr(d_addr),
    .d_wb_addr(d_wb_addr), .d_wb_data(d_wb_data),
    .gnt_i(gnt_i), .gnt_d(gnt_d), .beat(beat), .fill_data(fill_data),
    .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
    .i_done(i_done), .d_done(d_done),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial forever #5 clock = ~clock;
  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  // Content of main memory and of the D-cache victim, keyed by word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] victim_word(input logic [31:0] a);
    return (a * 32'h0101_0101) ^ 32'hDEAD_BEEF;
  endfunction

  assign mem_rdata = mem_word(mem_addr);
  assign d_wb_data = victim_word({d_wb_addr[31:5], beat, 2'b00});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model: one block transfer as the caches and memory see it.
  task automatic push_txn(input bit side, input logic [31:0] addr,
                          input bit dwb, input logic [31:0] wba);
    logic [31:0] base, wbase, a;
    base  = {addr[31:5], 5'b0};
    wbase = {wba[31:5], 5'b0};
    if (side && dwb) begin
      for (int k = 0; k < WORDS; k++) begin
        a = wbase + 32'(4 * k);
        sb.push_back('{K_WR, 1'b1, a, victim_word(a), k});
      end
    end
    for (int k = 0; k < WORDS; k++) begin
      a = base + 32'(4 * k);
      sb.push_back('{K_RD, side, a, mem_word(a), k});
    end
    sb.push_back('{K_DONE, side, 32'h0, 32'h0, 0});
  endtask

  // Issue one round of misses together, predict service order, and hold each
  // request until its done pulse. Latencies < 0 are not checked.
  task automatic run_round(input bit use_i, input bit use_d,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] wa, input bit dwb,
                           input int lat_i, input int lat_d);
    bit first;
    bit pend_i, pend_d;
    int start, budget;
    first = (use_i && use_d) ? ~model_last : use_d;
    push_txn(first, first ? da : ia, dwb, wa);
    if (use_i && use_d) push_txn(~first, ~first ? da : ia, dwb, wa);
    model_last = (use_i && use_d) ? ~first : first;
    @(negedge clock);
    i_addr = ia; d_addr = da; d_wb_addr = wa; d_wb = dwb;
    i_req = use_i; d_req = use_d;
    start = cycle_cnt; pend_i = use_i; pend_d = use_d; budget = 0;
    while ((pend_i || pend_d) && budget < 400) begin
      @(negedge clock);
      budget++;
      if (pend_i && i_done) begin
        i_req = 1'b0; pend_i = 1'b0;
        if (lat_i >= 0) check("lat_i", cycle_cnt - start, lat_i);
      end
      if (pend_d && d_done) begin
        d_req = 1'b0; pend_d = 1'b0;
        if (lat_d >= 0) check("lat_d", cycle_cnt - start, lat_d);
      end
    end
    check("round_timeout", {30'b0, pend_i, pend_d}, 32'h0);
    i_req = 1'b0; d_req = 1'b0;
  endtask

  // Memory handshake driver, updated just after each rising edge.
  initial forever begin
    @(posedge clock);
    #1;
    case (ready_mode)
      0: mem_ready = 1'b1;
      1: mem_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (mem_rd && beat == 3'd2 && stall_cnt < 3) begin
          mem_ready = 1'b0;
          stall_cnt++;
        end else begin
          mem_ready = 1'b1;
        end
      end
    endcase
  end

  // Monitor: protocol rules every cycle, scoreboard on every DUT event.
  initial begin : monitor
    exp_t        e;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [2:0]  prev_beat = '0;
    logic        prev_rd = 1'b0, prev_wr = 1'b0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        prev_stall = 1'b0;
        continue;
      end
      check("gnt_exclusive", gnt_i & gnt_d, 0);
      check("mem_exclusive", mem_rd & mem_wr, 0);
      check("fill_we_i_rule", fill_we_i, mem_rd & mem_ready & gnt_i);
      check("fill_we_d_rule", fill_we_d, mem_rd & mem_ready & gnt_d);
      if (prev_stall) begin
        check("stall_addr", mem_addr, prev_addr);
        check("stall_beat", beat, prev_beat);
        check("stall_op", {mem_rd, mem_wr}, {prev_rd, prev_wr});
      end
      prev_stall = (mem_rd || mem_wr) && !mem_ready;
      prev_addr = mem_addr; prev_beat = beat; prev_rd = mem_rd; prev_wr = mem_wr;

      if ((mem_wr || mem_rd) && mem_ready) begin
        check("beat_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("beat_kind", mem_wr ? K_WR : K_RD, e.kind);
          check("beat_addr", mem_addr, e.addr);
          check("beat_index", beat, e.beat);
          if (mem_wr) begin
            check("wb_wdata", mem_wdata, e.data);
          end else begin
            check("fill_data", fill_data, e.data);
            check("fill_side", {fill_we_i, fill_we_d}, {~e.side, e.side});
          end
        end
      end
      if (i_done || d_done) begin
        check("done_expected", sb.size() != 0, 1);
        check("done_quiet_mem", mem_rd | mem_wr, 0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("done_kind", K_DONE, e.kind);
          check("done_side", {i_done, d_done}, {~e.side, e.side});
          check("done_gnt", {gnt_i, gnt_d}, {~e.side, e.side});
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, {gnt_i, gnt_d, mem_rd, mem_wr, fill_we_i, fill_we_d,
                          i_done, d_done}, 0);
    check({tag, "_beat"}, beat, 0);
    check({tag, "_addr"}, mem_addr, 0);
  endtask

  initial begin : stimulus
    int budget;
    bit ui, ud;
    #1;
    check_idle_outputs("por");
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    // Ties from reset: D wins, then I; last grant is I again, so D wins again.
    run_round(1, 1, 32'h0000_3000, 32'h0000_4000, 32'h0, 0, 19, 9);
    run_round(1, 1, 32'h0000_3100, 32'h0000_4100, 32'h0, 0, 19, 9);
    // After a lone D transfer, a tie goes to I.
    run_round(0, 1, 32'h0, 32'h0000_4200, 32'h0, 0, -1, 9);
    run_round(1, 1, 32'h0000_3200, 32'h0000_4300, 32'h0, 0, 9, 19);

    // Single I miss with an unaligned address.
    run_round(1, 0, 32'h0000_1234, 32'h0, 32'h0, 0, 9, -1);
    // D miss with dirty victim.
    run_round(0, 1, 32'h0, 32'h0000_0200, 32'h0000_0100, 1, -1, 17);

    // Three wait states on beat 2.
    ready_mode = 2; stall_cnt = 0;
    run_round(1, 0, 32'h0000_2000, 32'h0, 32'h0, 0, 12, -1);
    check("stall_count", stall_cnt, 3);
    ready_mode = 0;

    // Reset in the middle of a refill.
    push_txn(1'b0, 32'h0000_5000, 1'b0, 32'h0);
    @(negedge clock);
    i_addr = 32'h0000_5000; i_req = 1'b1;
    budget = 0;
    do begin
      @(negedge clock);
      budget++;
    end while (!(mem_rd && beat == 3'd3) && budget < 50);
    check("reset_reach_beat3", {mem_rd, 29'b0, beat}, {1'b1, 29'b0, 3'd3});
    #1;
    resetn = 1'b0; i_req = 1'b0;
    sb.delete();
    model_last = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    @(negedge clock);
    check_idle_outputs("rst_held");
    resetn = 1'b1;
    run_round(1, 0, 32'h0000_0040, 32'h0, 32'h0, 0, 9, -1);

    // Randomised rounds with random memory wait states.
    for (int r = 0; r < 40; r++) begin
      ui = $urandom_range(0, 1);
      ud = ui ? 1'($urandom_range(0, 1)) : 1'b1;
      ready_mode = $urandom_range(0, 1);
      run_round(ui, ud, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), -1, -1);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    ready_mode = 0;
    repeat (2) @(negedge clock);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
